shifter_8bit: RTL and testbench

Registered 8-bit barrel rotator with parallel load, used as a clocked data-shaping stage in the datapath. Each rising clock edge either holds the stored word, loads a new word from `i`, or rotates the stored word left or right by 0–7 positions selected by `s`. The output `o` is the register contents.

---
 rtl/shifter_8bit_if.sv | 11 +
 rtl/shifter_8bit.sv | 62 ++++++
 tb/tb_shifter_8bit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/shifter_8bit_if.sv
// Signal bundle for the 8-bit rotator's data and control lines.
// The master side drives the operation and the slave side returns the registered word.
interface shifter_8bit_if;
  logic [7:0] i;
  logic [1:0] c;
  logic [2:0] s;
  logic [7:0] o;

  modport master (output i, output c, output s, input o);
  modport slave  (input i, input c, input s, output o);
endinterface

// File: rtl/shifter_8bit.sv
// Registered 8-bit barrel rotator with parallel load.
// Each rising edge either holds, rotates left/right by s, or loads i.
module shifter_8bit (
  output logic [7:0] o,
  input  logic [7:0] i,
  input  logic [1:0] c,
  input  logic [2:0] s,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_ROTL  = 2'b01,
    OP_ROTR  = 2'b10,
    OP_LOAD  = 2'b11
  } op_t;

  logic [7:0] r_reg;
  logic [7:0] r_next;

  // Stage k rotates by 2**k when s[k] is set; stage 0 is the stored word.
  logic [7:0] rol_stage [0:3];
  logic [7:0] ror_stage [0:3];

  assign rol_stage[0] = r_reg;
  assign ror_stage[0] = r_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign rol_stage[gi+1] = s[gi] ?
        {rol_stage[gi][7-SH:0], rol_stage[gi][7:8-SH]} : rol_stage[gi];
      assign ror_stage[gi+1] = s[gi] ?
        {ror_stage[gi][SH-1:0], ror_stage[gi][7:SH]} : ror_stage[gi];
    end
  endgenerate

  // The rotate networks are only selected for rotate ops, so an unknown s
  // during hold or load never reaches the register.
  always_comb begin
    r_next = r_reg;
    case (op_t'(c))
      OP_HOLD: r_next = r_reg;
      OP_ROTL: r_next = rol_stage[3];
      OP_ROTR: r_next = ror_stage[3];
      OP_LOAD: r_next = i;
      default: r_next = r_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= 8'h00;
    end else begin
      r_reg <= r_next;
    end
  end

  assign o = r_reg;

endmodule

// File: tb/tb_shifter_8bit.sv
// Self-checking bench for shifter_8bit: directed plan followed by random
// operations checked against a bit-index rotation model.
module tb_shifter_8bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_o;

  shifter_8bit_if bus ();

  shifter_8bit dut (
    .o     (bus.o),
    .i     (bus.i),
    .c     (bus.c),
    .s     (bus.s),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rot_left(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) r[(k + n) % 8] = v[k];
    return r;
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [1:0] cc,
                                            input logic [2:0] ss, input logic [7:0] ii);
    case (cc)
      2'b01:   return rot_left(cur, int'(ss));
      2'b10:   return rot_left(cur, (8 - int'(ss)) % 8);
      2'b11:   return ii;
      default: return cur;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] expv);
    checks++;
    assert (bus.o === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, bus.o, expv);
    end
  endtask

  // Apply one operation at the next edge, advance the model, compare.
  task automatic step(input string tag, input logic [1:0] cc, input logic [2:0] ss,
                      input logic [7:0] ii);
    @(negedge clk);
    bus.c = cc;
    bus.s = ss;
    bus.i = ii;
    @(posedge clk);
    #1;
    if (rst_n) exp_o = model_next(exp_o, cc, ss, ii);
    $display("op c=%b s=%b i=%b -> o=%b (expect %b) [%s]", cc, ss, ii, bus.o, exp_o, tag);
    check(tag, exp_o);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_o  = 8'h00;
    rst_n  = 1'b0;
    bus.c  = 2'b11;
    bus.s  = 3'b000;
    bus.i  = 8'hFF;

    // Reset held with a pending load.
    for (int k = 0; k < 3; k++) step("reset_hold", 2'b11, 3'b000, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_release_load", 2'b11, 3'b000, 8'hFF);

    // Pattern-invariant rotate.
    step("load_aa", 2'b11, 3'b010, 8'b10101010);
    for (int k = 0; k < 3; k++) step("rotl2_aa", 2'b01, 3'b010, 8'h00);

    // Left and right rotates.
    step("load_81", 2'b11, 3'b000, 8'b10000001);
    step("rotl3", 2'b01, 3'b011, 8'h00);
    step("rotr1", 2'b10, 3'b001, 8'h00);
    step("rotr7", 2'b10, 3'b111, 8'h00);

    // Hold with moving s/i, including unknown s, then zero-amount rotate.
    step("load_d3", 2'b11, 3'b000, 8'b11010011);
    step("hold_a", 2'b00, 3'b101, 8'h5A);
    step("hold_b", 2'b00, 3'bxxx, 8'hC3);
    step("hold_c", 2'b00, 3'b111, 8'h0F);
    step("rotl0", 2'b01, 3'b000, 8'hFF);
    step("rotr0", 2'b10, 3'b000, 8'hFF);
    step("load_sx", 2'b11, 3'bxxx, 8'h3C);

    // Full circle.
    step("load_01", 2'b11, 3'b000, 8'b00000001);
    for (int k = 0; k < 8; k++) step("walk", 2'b01, 3'b001, 8'h00);

    // Asynchronous reset between edges.
    step("load_b0", 2'b11, 3'b000, 8'b10110000);
    @(negedge clk);
    bus.c = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    exp_o = 8'h00;
    $display("async reset mid-cycle -> o=%b (expect %b)", bus.o, exp_o);
    check("async_reset", exp_o);
    rst_n = 1'b1;
    step("post_reset_rotl", 2'b01, 3'b011, 8'hFF);
    step("post_reset_hold", 2'b00, 3'b000, 8'hFF);
    step("post_reset_load", 2'b11, 3'b000, 8'hE7);

    // Random operations.
    for (int n = 0; n < 200; n++) begin
      step("random", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
